// File: rtl/fs_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fs_cell
//  Purpose  : Purely combinational 1-bit full subtractor. This is the leaf
//             cell that fs chains into a ripple-borrow subtractor.
//  Ports    : a, b  - minuend / subtrahend bit
//             bin   - incoming borrow
//             d     - difference bit, a ^ b ^ bin
//             bout  - outgoing borrow
//  Revision : 1.0  initial release
// ============================================================================
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    // A borrow is generated when a=0,b=1. When the bits are equal, an
    // incoming borrow propagates through the cell.
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule
`default_nettype wire

// File: rtl/fs.sv
`default_nettype none
// ============================================================================
//  Module   : fs
//  Purpose  : WIDTH-bit ripple-borrow full subtractor, D = A - B - Brin.
//             {Brout, D} is the (WIDTH+1)-bit two's-complement result.
//             The outputs are optionally registered (OUT_REG = 1, 1-cycle
//             latency, full throughput) or combinational (OUT_REG = 0).
//  Ports    : clk   - rising-edge clock (unused when OUT_REG = 0)
//             rst   - synchronous active-high reset (unused when OUT_REG = 0)
//             A, B  - WIDTH-bit unsigned minuend / subtrahend
//             Brin  - incoming borrow, weight 1
//             D     - WIDTH-bit difference
//             Brout - outgoing borrow, 1 when A < B + Brin
//  Revision : 1.0  initial release
// ============================================================================
module fs #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Brin,
    output logic [WIDTH-1:0] D,
    output logic             Brout
);

    // w_bin[i] is the borrow entering bit i; w_bin[WIDTH] leaves the MSB.
    logic [WIDTH:0]   w_bin;
    logic [WIDTH-1:0] w_d;

    assign w_bin[0] = Brin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fs_cell u_cell (
            .a    (A[i]),
            .b    (B[i]),
            .bin  (w_bin[i]),
            .d    (w_d[i]),
            .bout (w_bin[i+1])
        );
    end

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] r_d;
        logic             r_brout;

        // Reset wins over the data path; the in-flight result is dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_d     <= '0;
                r_brout <= 1'b0;
            end else begin
                r_d     <= w_d;
                r_brout <= w_bin[WIDTH];
            end
        end

        assign D     = r_d;
        assign Brout = r_brout;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic w_unused;
        assign w_unused = clk ^ rst;

        assign D     = w_d;
        assign Brout = w_bin[WIDTH];
    end

endmodule
`default_nettype wire

// File: tb/tb_fs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fs
//  Purpose  : Directed self-checking bench for fs. Four instances cover
//             WIDTH=1/8/16 registered and WIDTH=4 combinational builds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b0;

    always #5 clk = ~clk;

    // WIDTH = 1, registered
    logic       a1, b1, brin1, d1, brout1;
    // WIDTH = 8, registered
    logic [7:0] a8, b8, d8;
    logic       brin8, brout8;
    // WIDTH = 16, registered
    logic [15:0] a16, b16, d16;
    logic        brin16, brout16;
    // WIDTH = 4, combinational
    logic [3:0] a4, b4, d4;
    logic       brin4, brout4;

    fs #(.WIDTH(1), .OUT_REG(1'b1)) u_fs1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Brin(brin1), .D(d1), .Brout(brout1)
    );
    fs #(.WIDTH(8), .OUT_REG(1'b1)) u_fs8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Brin(brin8), .D(d8), .Brout(brout8)
    );
    fs #(.WIDTH(16), .OUT_REG(1'b1)) u_fs16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .Brin(brin16), .D(d16), .Brout(brout16)
    );
    fs #(.WIDTH(4), .OUT_REG(1'b0)) u_fs4 (
        .clk(clk), .rst(rst4), .A(a4), .B(b4), .Brin(brin4), .D(d4), .Brout(brout4)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Single-bit truth table {Brout, D} indexed by {A, B, Brin}.
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  key;
        logic [1:0]  prev;
        logic [16:0] exp17;

        a1 = 0; b1 = 0; brin1 = 0;
        a8 = 0; b8 = 0; brin8 = 0;
        a16 = 0; b16 = 0; brin16 = 0;
        a4 = 0; b4 = 0; brin4 = 0;

        // Reset state with non-zero inputs present.
        a8 = 8'h05; b8 = 8'h03; a1 = 1'b0; b1 = 1'b1;
        tick();
        check("rst_w1", {62'd0, brout1, d1}, 64'd0);
        check("rst_w8", {55'd0, brout8, d8}, 64'd0);
        check("rst_w16", {47'd0, brout16, d16}, 64'd0);
        rst = 1'b0;
        a1 = 0; b1 = 0;

        // WIDTH=1: binary count over (Brin,B,A); A toggles each period.
        prev = 2'b00;
        for (int v = 0; v < 8; v++) begin
            a1 = v[0]; b1 = v[1]; brin1 = v[2];
            key = {a1, b1, brin1};
            #1;
            // New inputs must not show before the capturing edge.
            if (v > 0) check($sformatf("hold_w1_%0d", v), {62'd0, brout1, d1}, {62'd0, prev});
            tick();
            check($sformatf("tt_w1_%0d", v), {62'd0, brout1, d1}, {62'd0, tt[key]});
            prev = tt[key];
        end

        // Explicit truth-table point (A,B,Brin)=(0,1,1) -> Brout=1, D=0.
        a1 = 0; b1 = 1; brin1 = 1;
        tick();
        check("tt_011", {62'd0, brout1, d1}, 64'h2);

        // WIDTH=8 reset mid-stream.
        a8 = 8'h05; b8 = 8'h03; brin8 = 0;
        tick();
        check("w8_pre", {55'd0, brout8, d8}, 64'h002);
        rst = 1'b1;
        tick();
        check("w8_rst", {55'd0, brout8, d8}, 64'h000);
        rst = 1'b0;
        tick();
        check("w8_post", {55'd0, brout8, d8}, 64'h002);

        // Wrap-around boundaries.
        a8 = 8'h00; b8 = 8'hFF; brin8 = 1;
        tick();
        check("w8_zero_minus_ones", {55'd0, brout8, d8}, 64'h100);
        a8 = 8'h10; b8 = 8'h10; brin8 = 1;
        tick();
        check("w8_eq_borrow", {55'd0, brout8, d8}, 64'h1FF);
        a8 = 8'hFF; b8 = 8'h00; brin8 = 0;
        tick();
        check("w8_ones_minus_zero", {55'd0, brout8, d8}, 64'h0FF);

        // WIDTH=16 random back-to-back vectors, checked one cycle later.
        for (int k = 0; k < 1000; k++) begin
            a16    = 16'($urandom);
            b16    = 16'($urandom);
            brin16 = 1'($urandom);
            exp17  = {1'b0, a16} - {1'b0, b16} - {16'd0, brin16};
            tick();
            check($sformatf("w16_rand_%0d", k), {47'd0, brout16, d16}, {47'd0, exp17});
        end

        // WIDTH=4 combinational: zero latency, reset ignored.
        a4 = 4'h3; b4 = 4'h7; brin4 = 0;
        #1;
        check("w4_comb", {59'd0, brout4, d4}, 64'h1C);
        rst4 = 1'b1;
        tick();
        check("w4_rst_hi", {59'd0, brout4, d4}, 64'h1C);
        rst4 = 1'b0;
        tick();
        check("w4_rst_lo", {59'd0, brout4, d4}, 64'h1C);
        a4 = 4'hF; b4 = 4'h0; brin4 = 1;
        #1;
        check("w4_comb2", {59'd0, brout4, d4}, 64'h0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
